// File: rtl/parking_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Package : parking_pkg                                            |
// | Purpose : Types and constants shared by the car-park gate        |
// |           controllers: gate FSM state encoding (common to the    |
// |           entrance and exit sides), active-low 7-segment digit   |
// |           patterns {g,f,e,d,c,b,a} and the default capacity.     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
package parking_pkg;

  // Encoding is shared with the entrance controller; do not reorder.
  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_WAIT_PASSWORD = 2'd1,
    ST_WRONG_PASS    = 2'd2,
    ST_OPEN          = 2'd3
  } gate_state_e;

  localparam int DEFAULT_CAPACITY = 20;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Non-BCD codes (10..15) blank the display rather than show garbage.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : seven_seg_decode                                       |
// | Purpose : Registered BCD to active-low 7-segment decoder.        |
// | Ports   : clk    in  1  clock                                    |
// |           reset  in  1  synchronous active-high reset (blank)    |
// |           bcd_i  in  4  BCD digit                                |
// |           seg_o  out 7  segments {g,f,e,d,c,b,a}, active low     |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module seven_seg_decode
  import parking_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  logic [6:0] seg_q;

  always_ff @(posedge clk) begin
    if (reset) seg_q <= SEG_BLANK;
    else       seg_q <= bcd_to_seg(bcd_i);
  end

  assign seg_o = seg_q;

endmodule
`default_nettype wire

// File: rtl/parking_exit_gate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : parking_exit_gate                                      |
// | Purpose : Exit barrier controller. Checks a 2-digit exit code,   |
// |           opens the barrier, counts departures, keeps the shared |
// |           occupancy count and shows free spaces on two 7-seg     |
// |           digits.                                                |
// | Ports   : clk, reset            clock / sync active-high reset   |
// |           sensor_exit           car waiting at exit loop (level) |
// |           sensor_clear          car passed the barrier (level)   |
// |           car_entered           1-cycle pulse per admitted car   |
// |           password_1/2 [1:0]    exit code digits                 |
// |           GREEN_LED, RED_LED    barrier lamps (registered)       |
// |           HEX_1 / HEX_2 [6:0]   free-space tens / ones, act. low |
// |           full                  occupancy == CAPACITY            |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module parking_exit_gate
  import parking_pkg::*;
#(
  parameter int         CAPACITY    = DEFAULT_CAPACITY,
  parameter int         WAIT_CYCLES = 3,
  parameter int         TIMEOUT     = 16,
  parameter logic [1:0] EXIT_PASS_1 = 2'b10,
  parameter logic [1:0] EXIT_PASS_2 = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_exit,
  input  logic       sensor_clear,
  input  logic       car_entered,
  input  logic [1:0] password_1,
  input  logic [1:0] password_2,
  output logic       GREEN_LED,
  output logic       RED_LED,
  output logic [6:0] HEX_1,
  output logic [6:0] HEX_2,
  output logic       full
);

  localparam int OCC_W  = $clog2(CAPACITY + 1);
  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [OCC_W-1:0]  CAP_OCC   = OCC_W'(CAPACITY);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

  gate_state_e       state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [TMO_W-1:0]  tmo_cnt_q;
  logic              green_q, red_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              full_q;

  logic       pass_ok;
  logic       depart;
  logic [6:0] free;
  logic [3:0] tens, ones;

  assign pass_ok = (password_1 == EXIT_PASS_1) && (password_2 == EXIT_PASS_2);
  assign depart  = (state_q == ST_OPEN) && sensor_clear;

  // Saturating occupancy; a departure and an admission in the same
  // cycle cancel out.
  always_comb begin
    occ_d = occ_q;
    if (depart && !car_entered) begin
      if (occ_q != '0) occ_d = occ_q - 1'b1;
    end else if (car_entered && !depart) begin
      if (occ_q != CAP_OCC) occ_d = occ_q + 1'b1;
    end
  end

  // Gate FSM. LEDs are loaded from the state being entered so they
  // change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      green_q    <= 1'b0;
      red_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // An empty car park has nobody to let out.
          if (sensor_exit && occ_q != '0) begin
            state_q    <= ST_WAIT_PASSWORD;
            wait_cnt_q <= '0;
            red_q      <= 1'b1;
            green_q    <= 1'b0;
          end
        end
        ST_WAIT_PASSWORD: begin
          if (wait_cnt_q == WAIT_LAST) begin
            wait_cnt_q <= '0;
            if (pass_ok) begin
              state_q <= ST_OPEN;
              green_q <= 1'b1;
              red_q   <= 1'b0;
            end else begin
              state_q   <= ST_WRONG_PASS;
              tmo_cnt_q <= '0;
              red_q     <= ~red_q;
              green_q   <= 1'b0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        ST_WRONG_PASS: begin
          if (pass_ok) begin
            state_q   <= ST_OPEN;
            tmo_cnt_q <= '0;
            green_q   <= 1'b1;
            red_q     <= 1'b0;
          end else if (sensor_exit) begin
            tmo_cnt_q <= '0;
            red_q     <= ~red_q;
          end else if (tmo_cnt_q == TMO_LAST) begin
            // Car backed away from the loop: give up on it.
            state_q   <= ST_IDLE;
            tmo_cnt_q <= '0;
            red_q     <= 1'b0;
            green_q   <= 1'b0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            red_q     <= ~red_q;
          end
        end
        ST_OPEN: begin
          if (sensor_clear) begin
            green_q <= 1'b0;
            if (sensor_exit) begin
              // Next car already queued: go straight to code entry.
              state_q    <= ST_WAIT_PASSWORD;
              wait_cnt_q <= '0;
              red_q      <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              red_q   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          green_q <= 1'b0;
          red_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q  <= '0;
      full_q <= 1'b0;
    end else begin
      occ_q  <= occ_d;
      full_q <= (occ_q == CAP_OCC);
    end
  end

  // CAPACITY <= 99 so free always fits in 7 bits and splits cleanly
  // into two BCD digits.
  assign free = 7'(CAP_OCC - occ_q);
  assign tens = 4'(free / 7'd10);
  assign ones = 4'(free % 7'd10);

  seven_seg_decode u_hex_tens (
    .clk   (clk),
    .reset (reset),
    .bcd_i (tens),
    .seg_o (HEX_1)
  );

  seven_seg_decode u_hex_ones (
    .clk   (clk),
    .reset (reset),
    .bcd_i (ones),
    .seg_o (HEX_2)
  );

  assign GREEN_LED = green_q;
  assign RED_LED   = red_q;
  assign full      = full_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_exit_gate.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_parking_exit_gate                                   |
// | Purpose : Randomized self-checking bench for parking_exit_gate.  |
// |           A behavioural model tracks occupancy as an integer and |
// |           the gate as a mode with simple cycle tallies; every    |
// |           output is compared every cycle.                        |
// | Rev     : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_parking_exit_gate;

  localparam int         CAP   = 20;
  localparam int         WAITC = 3;
  localparam int         TMO   = 16;
  localparam logic [1:0] PW1   = 2'b10;
  localparam logic [1:0] PW2   = 2'b01;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_WRONG = 2;
  localparam int M_OPEN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sensor_exit = 1'b0;
  logic       sensor_clear = 1'b0;
  logic       car_entered = 1'b0;
  logic [1:0] password_1 = 2'b00;
  logic [1:0] password_2 = 2'b00;
  logic       GREEN_LED, RED_LED, full;
  logic [6:0] HEX_1, HEX_2;

  always #5 clk = ~clk;

  parking_exit_gate #(
    .CAPACITY    (CAP),
    .WAIT_CYCLES (WAITC),
    .TIMEOUT     (TMO),
    .EXIT_PASS_1 (PW1),
    .EXIT_PASS_2 (PW2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sensor_exit  (sensor_exit),
    .sensor_clear (sensor_clear),
    .car_entered  (car_entered),
    .password_1   (password_1),
    .password_2   (password_2),
    .GREEN_LED    (GREEN_LED),
    .RED_LED      (RED_LED),
    .HEX_1        (HEX_1),
    .HEX_2        (HEX_2),
    .full         (full)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at t=%0t: got %b expected %b", tag, $time, got[6:0], exp[6:0]);
    end
  endtask

  // Display patterns written out independently of the design package.
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- reference model ----------------
  int         m_mode, m_occ, m_waited, m_low;
  logic       e_green, e_red, e_full;
  logic [6:0] e_hex1, e_hex2;

  task automatic model_step();
    int  occ_pre;
    bit  ok, dep;
    occ_pre = m_occ;
    if (reset) begin
      m_mode = M_IDLE; m_occ = 0; m_waited = 0; m_low = 0;
      e_green = 1'b0; e_red = 1'b0; e_full = 1'b0;
      e_hex1 = 7'b1111111; e_hex2 = 7'b1111111;
      return;
    end
    // Displays and full lag the occupancy register by one cycle.
    e_hex1 = seg_of((CAP - occ_pre) / 10);
    e_hex2 = seg_of((CAP - occ_pre) % 10);
    e_full = (occ_pre == CAP);

    ok  = (password_1 == PW1) && (password_2 == PW2);
    dep = (m_mode == M_OPEN) && sensor_clear;
    if (dep && !car_entered)      m_occ = (m_occ > 0)   ? m_occ - 1 : 0;
    else if (car_entered && !dep) m_occ = (m_occ < CAP) ? m_occ + 1 : CAP;

    case (m_mode)
      M_IDLE: if (sensor_exit && occ_pre > 0) begin m_mode = M_WAIT; m_waited = 0; end
      M_WAIT: begin
        m_waited++;
        if (m_waited == WAITC) begin
          m_mode = ok ? M_OPEN : M_WRONG;
          m_low  = 0;
        end
      end
      M_WRONG: begin
        if (ok) m_mode = M_OPEN;
        else if (sensor_exit) m_low = 0;
        else begin
          m_low++;
          if (m_low == TMO) m_mode = M_IDLE;
        end
      end
      default: if (sensor_clear) begin
        m_mode   = sensor_exit ? M_WAIT : M_IDLE;
        m_waited = 0;
      end
    endcase

    e_green = (m_mode == M_OPEN);
    if (m_mode == M_WAIT)       e_red = 1'b1;
    else if (m_mode == M_WRONG) e_red = ~e_red;
    else                        e_red = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int p_rst, p_tog, p_ok, p_sc, p_ce, se_force;

  task automatic drive_random();
    reset = ($urandom_range(999) < p_rst);
    if (se_force >= 0) sensor_exit = se_force[0];
    else if ($urandom_range(99) < p_tog) sensor_exit = ~sensor_exit;
    sensor_clear = ($urandom_range(99) < p_sc);
    car_entered  = ($urandom_range(99) < p_ce);
    if ($urandom_range(99) < 40) begin
      if ($urandom_range(99) < p_ok) begin
        password_1 = PW1; password_2 = PW2;
      end else begin
        password_1 = 2'($urandom_range(3));
        password_2 = 2'($urandom_range(3));
      end
    end
  endtask

  task automatic check_all();
    check("green", 32'(GREEN_LED), 32'(e_green));
    check("red",   32'(RED_LED),   32'(e_red));
    check("hex1",  32'(HEX_1),     32'(e_hex1));
    check("hex2",  32'(HEX_2),     32'(e_hex2));
    check("full",  32'(full),      32'(e_full));
  endtask

  task automatic run(input int n, input int rst, input int tog, input int okp,
                     input int sc, input int ce, input int sef);
    p_rst = rst; p_tog = tog; p_ok = okp; p_sc = sc; p_ce = ce; se_force = sef;
    repeat (n) begin
      @(negedge clk);
      check_all();
      drive_random();
      model_step();
    end
  endtask

  initial begin
    model_step();                          // reset is high from time 0
    run(2,    1000, 0,  0,  0,  0,  0);    // hold reset
    run(6,    0,    0,  0,  0,  0,  1);    // empty park, car at exit: stays idle
    run(2500, 3,    10, 60, 30, 15, -1);   // mixed traffic
    run(80,   0,    0,  60, 20, 60, 0);    // fill up and saturate
    run(400,  0,    2,  90, 40, 5,  1);    // steady departures, queued cars
    run(1500, 0,    20, 10, 30, 12, -1);   // mostly wrong codes, timeouts
    run(800,  2,    10, 60, 30, 25, -1);   // mixed again with resets
    @(negedge clk);
    check_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parking_exit_gate.md
# parking_exit_gate

Exit-side barrier controller for the car park, the counterpart of the entrance gate controller. It detects a car at the exit loop, checks a 2-digit exit code, opens the barrier, and confirms departure on the clear sensor. It keeps the shared occupancy count, incremented by the entrance block's per-car pulse and decremented here on each departure. It drives the free-space count on two 7-segment displays and the `full` flag back to the entrance side.

## Interface
- `CAPACITY`, default 20: number of parking spaces; legal range 1..99.
- `WAIT_CYCLES`, default 3: cycles spent in WAIT_PASSWORD before the code is sampled.
- `TIMEOUT`, default 16: cycles in WRONG_PASS with `sensor_exit` low before returning to IDLE.
- `EXIT_PASS_1`, default 2'b10 and `EXIT_PASS_2`, default 2'b01: the exit code.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sensor_exit`  in  1  car present at the exit loop (level).
- `sensor_clear`  in  1  car has passed the barrier (level).
- `car_entered`  in  1  one-cycle pulse from the entrance controller per admitted car.
- `password_1`, `password_2`  in  2 each  exit code digits.
- `GREEN_LED`, `RED_LED`  out  1 each  barrier status lamps.
- `HEX_1`, `HEX_2`  out  7 each  free-space tens / ones digit; active-low segments {g,f,e,d,c,b,a}.
- `full`  out  1  occupancy == CAPACITY.

## Operation
- Occupancy counter `occ`: width $clog2(CAPACITY+1); free = CAPACITY − occ.
- FSM states: IDLE, WAIT_PASSWORD, WRONG_PASS, OPEN.
- IDLE: if `sensor_exit` && occ != 0 → WAIT_PASSWORD. When occ == 0, `sensor_exit` is ignored.
- WAIT_PASSWORD: the wait counter counts `WAIT_CYCLES` cycles, then the code is sampled. Match on both digits → OPEN; otherwise → WRONG_PASS.
- WRONG_PASS: the code is sampled every cycle; a match → OPEN.
  - The timeout counter runs while `sensor_exit` is low and is cleared while it is high.
  - When the counter reaches `TIMEOUT` → IDLE.
- OPEN: on `sensor_clear`, a departure is counted.
  - If `sensor_exit` is also high (next car queued) → WAIT_PASSWORD.
  - Otherwise → IDLE.
- Occupancy update:
  - A departure decrements `occ`; it saturates at 0.
  - `car_entered` increments `occ`; it saturates at CAPACITY.
  - A departure and `car_entered` in the same cycle leave `occ` unchanged.
- LEDs per state:
  - IDLE: both off.
  - WAIT_PASSWORD: RED on.
  - WRONG_PASS: RED toggles every cycle, GREEN off.
  - OPEN: GREEN on, RED off.
- HEX digits:
  - tens = free/10, ones = free%10.
  - Encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - A tens digit of 0 is shown as 0, not blanked.

## Timing
- All outputs are registered.
- Reset values: FSM IDLE, occ 0, both counters 0, LEDs 0, `full` 0, HEX_1/HEX_2 7'b1111111 (blank).
- The cycle after reset releases, the HEX outputs show CAPACITY.
- A state change is visible on the LEDs 1 cycle after the triggering input edge.
- An `occ` change is visible on `full` and HEX 1 cycle after the `occ` register updates (2 cycles after the input).
- The WAIT_PASSWORD → sample decision happens on the `WAIT_CYCLES`-th cycle in the state.
- Reset asserted mid-operation overrides everything in that cycle; `occ` is cleared.
- `sensor_clear` outside OPEN is ignored.

## Structure
- Shared package `parking_pkg`:
  - FSM state enum (shared encoding with the entrance controller).
  - 7-segment digit constants.
  - Default capacity constant.
- Sub-module `seven_seg_decode`: 4-bit BCD in, registered 7-bit active-low out. Instantiated twice.
- Binary-to-BCD conversion uses a constant divide/modulo by 10, legal for values 0..99.

## Test plan
- Reset, then idle for 2 cycles → HEX_1=0100100, HEX_2=1000000 (free 20), `full`=0, both LEDs 0.
- Pulse `car_entered` once, then assert `sensor_exit` with code 10/01 held, then `sensor_clear` in OPEN → RED for 3 cycles, then GREEN. `occ` returns 0 and HEX shows 20.
- With occ=1, apply wrong code 01/10 → RED toggles each cycle. Switch to 10/01 → OPEN the next cycle. Separately, drop `sensor_exit` with a wrong code for 16 cycles → IDLE.
- Twenty `car_entered` pulses → `full`=1, HEX 1000000/1000000. A 21st pulse → occ stays 20. `car_entered` coinciding with a departure → occ unchanged.
- occ=2; `sensor_clear` and `sensor_exit` high together in OPEN → WAIT_PASSWORD directly, occ=1.
- occ=0 with `sensor_exit` high → stays IDLE with LEDs off. Assert `reset` while in OPEN → all outputs return to their reset values on the next edge.
